// File: rtl/teak_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : teak_action_ctrl
// Description : AXI4-Lite register slave that starts an external action
//               (four-phase go/done handshakes), raises a level interrupt on
//               completion, and serves kernel parameters over a separate
//               four-phase address/data handshake.
// Ports       : clk, reset (async active-low)
//               s_axi_*     AXI4-Lite slave (CTRL 0x00, IER 0x04, ISR 0x08,
//                           PARAM[i] at 0x10+4*i)
//               go_0r/go_0a, done_0r/done_0a   action start / completion
//               param_addr*/param_data*        parameter fetch handshake
//               irq         IER[0] & ISR[0]
// Revision    : 1.0 - initial release
// ============================================================================
module teak_action_ctrl #(
  parameter int PARAM_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  input  logic        param_addr_0r,
  input  logic [31:0] param_addr,
  output logic        param_addr_0a,
  output logic        param_data_0r,
  output logic [31:0] param_data,
  input  logic        param_data_0a,
  output logic        irq
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GO_REQ   = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_DONE_ACK = 2'd3;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_ADDR = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_REL  = 2'd3;

  logic [1:0]  r_state, r_pstate;
  logic        r_arready, r_rvalid, r_awready, r_bvalid;
  logic [31:0] r_rdata, r_pdata;
  logic        r_done, r_ier, r_isr;
  logic [31:0] r_param [PARAM_WORDS];

  logic [5:0]  w_rd_word, w_wr_word;
  logic [31:0] w_rd_data, w_plookup;
  logic        w_busy, w_idle, w_rd_hs, w_wr_hs;
  logic        w_done_set, w_done_clr, w_isr_clr, w_start;
  logic        w_unused;

  assign w_rd_word = s_axi_araddr[7:2];
  assign w_wr_word = s_axi_awaddr[7:2];
  assign w_busy    = (r_state != S_IDLE);
  assign w_idle    = (r_state == S_IDLE);
  // ready is raised only while the master holds valid, so the cycle with
  // ready high is the handshake cycle
  assign w_rd_hs   = r_arready;
  assign w_wr_hs   = r_awready;

  assign w_start    = w_wr_hs && (w_wr_word == 6'd0) && s_axi_wdata[0];
  assign w_done_set = (r_state == S_DONE_ACK) && !done_0r;
  // only clear a DONE that this read actually returned
  assign w_done_clr = w_rd_hs && (w_rd_word == 6'd0) && r_done;
  assign w_isr_clr  = w_wr_hs && (w_wr_word == 6'd2) && s_axi_wdata[0];

  always_comb begin
    w_rd_data = '0;
    case (w_rd_word)
      6'd0: w_rd_data = {29'd0, w_idle, r_done, w_busy};
      6'd1: w_rd_data = {31'd0, r_ier};
      6'd2: w_rd_data = {31'd0, r_isr};
      default: begin
        for (int i = 0; i < PARAM_WORDS; i++) begin
          if (w_rd_word == 6'(i + 4)) w_rd_data = r_param[i];
        end
      end
    endcase
  end

  // full 32-bit index compare: out-of-range indices yield zero
  always_comb begin
    w_plookup = '0;
    for (int i = 0; i < PARAM_WORDS; i++) begin
      if (param_addr == 32'(i)) w_plookup = r_param[i];
    end
  end

  // AXI read channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else if (r_arready) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b1;
      r_rdata   <= w_rd_data;
    end else if (r_rvalid) begin
      if (s_axi_rready) r_rvalid <= 1'b0;
    end else if (s_axi_arvalid) begin
      r_arready <= 1'b1;
    end
  end

  // AXI write channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else if (r_awready) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b1;
    end else if (r_bvalid) begin
      if (s_axi_bready) r_bvalid <= 1'b0;
    end else if (s_axi_awvalid && s_axi_wvalid) begin
      r_awready <= 1'b1;
    end
  end

  // Control/status registers; set beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_ier  <= 1'b0;
      r_isr  <= 1'b0;
    end else begin
      if (w_done_set)      r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      if (w_done_set)      r_isr  <= 1'b1;
      else if (w_isr_clr)  r_isr  <= 1'b0;
      if (w_wr_hs && (w_wr_word == 6'd1)) r_ier <= s_axi_wdata[0];
    end
  end

  // Parameter registers: byte-strobed, frozen while an action is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PARAM_WORDS; i++) r_param[i] <= '0;
    end else if (w_wr_hs && !w_busy) begin
      for (int i = 0; i < PARAM_WORDS; i++) begin
        if (w_wr_word == 6'(i + 4)) begin
          for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) r_param[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Action FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start && !go_0a) r_state <= S_GO_REQ;
        S_GO_REQ:   if (go_0a)             r_state <= S_RUN;
        S_RUN:      if (done_0r)           r_state <= S_DONE_ACK;
        S_DONE_ACK: if (!done_0r)          r_state <= S_IDLE;
        default:                           r_state <= S_IDLE;
      endcase
    end
  end

  // Parameter fetch FSM; value latched once per transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pstate <= P_IDLE;
      r_pdata  <= '0;
    end else begin
      case (r_pstate)
        P_IDLE: if (param_addr_0r) begin
          r_pdata  <= w_plookup;
          r_pstate <= P_ADDR;
        end
        P_ADDR:  if (!param_addr_0r) r_pstate <= P_DATA;
        P_DATA:  if (param_data_0a)  r_pstate <= P_REL;
        P_REL:   if (!param_data_0a) r_pstate <= P_IDLE;
        default:                     r_pstate <= P_IDLE;
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_awready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign go_0r         = (r_state == S_GO_REQ);
  assign done_0a       = (r_state == S_DONE_ACK);
  assign param_addr_0a = (r_pstate == P_ADDR);
  assign param_data_0r = (r_pstate == P_DATA);
  assign param_data    = r_pdata;
  assign irq           = r_ier & r_isr;

  assign w_unused = ^{s_axi_araddr[31:8], s_axi_araddr[1:0], s_axi_awaddr[31:8],
                      s_axi_awaddr[1:0], s_axi_arcache, s_axi_arprot,
                      s_axi_awcache, s_axi_awprot};

endmodule
`default_nettype wire

// File: tb/tb_teak_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_teak_action_ctrl
// Description : Directed self-checking bench for teak_action_ctrl. Expected
//               AXI read data and parameter values are queued when stimulus
//               is issued and compared when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_teak_action_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  logic [3:0]  s_axi_wstrb;
  logic        go_0r, go_0a, done_0r, done_0a;
  logic        param_addr_0r, param_addr_0a, param_data_0r, param_data_0a;
  logic [31:0] param_addr, param_data;
  logic        irq;

  logic        lb_en = 1'b0;
  logic        lb_q = 1'b0;
  logic        go_ack_m, done_req_m;
  int          go_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // loopback: go_0a and done_0r both driven by one flop following go_0r
  always @(posedge clk) lb_q <= go_0r;
  always @(posedge clk) if (go_0r) go_cnt <= go_cnt + 1;
  assign go_0a   = lb_en ? lb_q : go_ack_m;
  assign done_0r = lb_en ? lb_q : done_req_m;

  teak_action_ctrl #(.PARAM_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arcache(4'h3), .s_axi_arprot(3'h0), .s_axi_awcache(4'h3), .s_axi_awprot(3'h0),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_addr_0r(param_addr_0r), .param_addr(param_addr), .param_addr_0a(param_addr_0a),
    .param_data_0r(param_data_0r), .param_data(param_data), .param_data_0a(param_data_0a),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT", tag);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi_arready) begin
      tmo(tag); s_axi_arvalid = 1'b0; e = exp_q.pop_front(); return;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    if (!s_axi_rvalid) begin tmo(tag); return; end
    chk(tag, s_axi_rdata, e);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    int n;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi_awready) begin
      tmo(tag); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; return;
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    if (!s_axi_bvalid) begin tmo(tag); return; end
    chk({tag, "_bresp"}, {30'd0, s_axi_bresp}, 32'd0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic param_xfer(input logic [31:0] idx, input logic [31:0] exp, input string tag);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    param_addr    = idx;
    param_addr_0r = 1'b1;
    n = 0;
    while (!param_addr_0a && n < 20) begin @(negedge clk); n++; end
    if (!param_addr_0a) begin tmo(tag); param_addr_0r = 1'b0; e = exp_q.pop_front(); return; end
    param_addr_0r = 1'b0;
    n = 0;
    while (!param_data_0r && n < 20) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    if (!param_data_0r) begin tmo(tag); return; end
    chk(tag, param_data, e);
    param_data_0a = 1'b1;
    n = 0;
    while (param_data_0r && n < 20) begin @(negedge clk); n++; end
    if (param_data_0r) tmo({tag, "_rel"});
    param_data_0a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_sig(input logic want_done_hi, input string tag);
    int n;
    n = 0;
    while ((done_0a !== want_done_hi) && n < 40) begin @(negedge clk); n++; end
    if (done_0a !== want_done_hi) tmo(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    reset = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    go_ack_m = 1'b0; done_req_m = 1'b0;
    param_addr_0r = 1'b0; param_addr = '0; param_data_0a = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_go", {31'd0, go_0r}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    chk("rst_pdata", param_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    axi_read(32'h00, 32'h4, "ctrl_idle");
    axi_read(32'h04, 32'h0, "ier_reset");

    // strobed PARAM write
    axi_write(32'h18, 32'h0, 4'hF, "p2_clear");
    axi_write(32'h18, 32'hDEADBEEF, 4'b0011, "p2_strb");
    axi_read(32'h18, 32'h0000BEEF, "p2_read");
    axi_read(32'h40, 32'h0, "unmapped_40");
    axi_read(32'h0C, 32'h0, "unmapped_0c");

    // parameter handshake
    axi_write(32'h14, 32'h12345678, 4'hF, "p1_write");
    param_xfer(32'd1, 32'h12345678, "pfetch_1");
    param_xfer(32'd100, 32'h0, "pfetch_100");
    param_xfer(32'h0000_0102, 32'h0, "pfetch_hi_bits");

    // loopback action with interrupt
    axi_write(32'h04, 32'h1, 4'hF, "ier_set");
    lb_en = 1'b1;
    g0 = go_cnt;
    axi_write(32'h00, 32'h1, 4'hF, "start_lb");
    wait_sig(1'b1, "lb_done_hi");
    wait_sig(1'b0, "lb_done_lo");
    chk("lb_go_pulsed", {31'd0, go_cnt > g0}, 32'd1);
    chk("lb_irq", {31'd0, irq}, 32'd1);
    axi_read(32'h00, 32'h6, "ctrl_done");
    axi_read(32'h00, 32'h4, "ctrl_done_clr");
    axi_read(32'h08, 32'h1, "isr_set");
    axi_write(32'h08, 32'h1, 4'hF, "isr_w1c");
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(32'h08, 32'h0, "isr_clr");
    lb_en = 1'b0;
    @(negedge clk);

    // writes during RUN are ignored
    axi_write(32'h00, 32'h1, 4'hF, "start_man");
    chk("goreq_go", {31'd0, go_0r}, 32'd1);
    go_ack_m = 1'b1;
    @(negedge clk);
    chk("run_go_low", {31'd0, go_0r}, 32'd0);
    go_ack_m = 1'b0;
    axi_write(32'h00, 32'h1, 4'hF, "start_busy");
    axi_write(32'h14, 32'hFFFFFFFF, 4'hF, "p1_busy");
    axi_read(32'h00, 32'h1, "ctrl_busy");
    axi_read(32'h14, 32'h12345678, "p1_unchanged");
    done_req_m = 1'b1;
    wait_sig(1'b1, "man_done_hi");
    done_req_m = 1'b0;
    @(negedge clk);
    chk("man_done_lo", {31'd0, done_0a}, 32'd0);
    chk("no_restart", {31'd0, go_0r}, 32'd0);
    chk("man_irq", {31'd0, irq}, 32'd1);
    axi_read(32'h00, 32'h6, "ctrl_done2");

    // reset during GO_REQ and P_DATA
    axi_write(32'h00, 32'h1, 4'hF, "start_rst");
    param_addr = 32'd2;
    param_addr_0r = 1'b1;
    repeat (3) @(negedge clk);
    param_addr_0r = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_go", {31'd0, go_0r}, 32'd1);
    chk("pre_rst_pdr", {31'd0, param_data_0r}, 32'd1);
    chk("pre_rst_pdata", param_data, 32'h0000BEEF);
    #2 reset = 1'b0;
    #1;
    chk("arst_go", {31'd0, go_0r}, 32'd0);
    chk("arst_pdr", {31'd0, param_data_0r}, 32'd0);
    chk("arst_pdata", param_data, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    axi_read(32'h00, 32'h4, "post_ctrl");
    axi_read(32'h04, 32'h0, "post_ier");
    axi_read(32'h08, 32'h0, "post_isr");
    axi_read(32'h14, 32'h0, "post_p1");
    axi_read(32'h18, 32'h0, "post_p2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
